// File: rtl/spu_regfile_mp.sv
// Multi-port register file for the SPU dual-issue pipeline.
// Registered reads with per-port write-first bypass, highest-index write
// port wins on collisions, and a per-register latency scoreboard that
// drives registered RAW hazard flags back to issue.
// All multi-port vectors are big-endian: port i sits in [i*W : i*W+W-1].

// One read lane: bypass select plus the output registers for data/hazard.
module spu_regfile_mp_rdport #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int NUM_WR = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [ADDR_W-1:0]                addr,
  input  logic                             in_range,
  input  logic [DATA_W-1:0]                arr_val,
  input  logic                             busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]                data,
  output logic                             hazard
);
  logic [DATA_W-1:0] nxt;
  logic              hit;

  // Write-first bypass; the loop order makes the highest matching port win.
  always_comb begin
    hit = 1'b0;
    nxt = arr_val;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && (wr_addr[p] == addr)) begin
        hit = 1'b1;
        nxt = wr_data[p];
      end
    end
    if (!in_range) begin
      hit = 1'b0;
      nxt = '0;
    end
  end

  // Output registers hold their value while the port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data   <= '0;
      hazard <= 1'b0;
    end else if (en) begin
      data   <= nxt;
      hazard <= busy && !hit;
    end
  end
endmodule

module spu_regfile_mp #(
  parameter int DATA_W = 128,
  parameter int NREGS  = 128,
  parameter int ADDR_W = 7,
  parameter int NUM_RD = 5,
  parameter int NUM_WR = 2,
  parameter int LAT_W  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [0:NUM_RD-1]            rd_en,
  input  logic [0:NUM_RD*ADDR_W-1]     rd_addr,
  output logic [0:NUM_RD*DATA_W-1]     rd_data,
  output logic [0:NUM_RD-1]            rd_hazard,
  input  logic [0:NUM_WR-1]            wr_en,
  input  logic [0:NUM_WR*ADDR_W-1]     wr_addr,
  input  logic [0:NUM_WR*DATA_W-1]     wr_data,
  input  logic [0:NUM_WR-1]            iss_valid,
  input  logic [0:NUM_WR*ADDR_W-1]     iss_addr,
  input  logic [0:NUM_WR*LAT_W-1]      iss_lat,
  output logic                         err_waw
);
  // Per-port views of the packed input vectors.
  logic [NUM_WR-1:0]                we, iv;
  logic [NUM_WR-1:0][ADDR_W-1:0]    wa, ia;
  logic [NUM_WR-1:0][DATA_W-1:0]    wd;
  logic [NUM_WR-1:0][LAT_W-1:0]     il;
  logic [NUM_RD-1:0][ADDR_W-1:0]    ra;
  logic [NUM_RD-1:0][DATA_W-1:0]    rq;

  logic [DATA_W-1:0] regs    [NREGS];
  logic [LAT_W-1:0]  cnt     [NREGS];
  logic [LAT_W-1:0]  cnt_nxt [NREGS];

  logic [NREGS-1:0][NUM_WR-1:0] wr_hit, iss_hit;
  logic [NUM_RD-1:0][DATA_W-1:0] arr_val;
  logic [NUM_RD-1:0]             busy, in_rng;
  logic                          waw;

  genvar g;
  generate
    for (g = 0; g < NUM_WR; g++) begin : g_wunpack
      assign we[g] = wr_en[g];
      assign iv[g] = iss_valid[g];
      assign wa[g] = wr_addr[g*ADDR_W +: ADDR_W];
      assign ia[g] = iss_addr[g*ADDR_W +: ADDR_W];
      assign wd[g] = wr_data[g*DATA_W +: DATA_W];
      assign il[g] = iss_lat[g*LAT_W +: LAT_W];
    end
    for (g = 0; g < NUM_RD; g++) begin : g_rpack
      assign ra[g] = rd_addr[g*ADDR_W +: ADDR_W];
      assign rd_data[g*DATA_W +: DATA_W] = rq[g];
    end
  endgenerate

  // Address decode per register; out-of-range addresses match nothing.
  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        wr_hit[r][p]  = we[p] && (wa[p] == ADDR_W'(r));
        iss_hit[r][p] = iv[p] && (il[p] != '0) && (ia[p] == ADDR_W'(r));
      end
    end
  end

  // Two or more enabled write ports landing on the same register.
  always_comb begin
    waw = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        for (int q = p + 1; q < NUM_WR; q++) begin
          if (wr_hit[r][p] && wr_hit[r][q]) waw = 1'b1;
        end
      end
    end
  end

  // Scoreboard next state: issue load beats writeback clear beats decrement.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt[r] = cnt[r];
      if (cnt[r] != '0) cnt_nxt[r] = cnt[r] - LAT_W'(1);
      if (|wr_hit[r]) cnt_nxt[r] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (iss_hit[r][p]) cnt_nxt[r] = il[p];
      end
    end
  end

  // Array lookup and pending state for each read port.
  always_comb begin
    arr_val = '0;
    busy    = '0;
    in_rng  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (ra[i] == ADDR_W'(r)) begin
          arr_val[i] = regs[r];
          busy[i]    = (cnt[r] != '0);
          in_rng[i]  = 1'b1;
        end
      end
    end
  end

  // Array write; later ports in the loop override earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_hit[r][p]) regs[r] <= wd[p];
        end
      end
    end
  end

  // Scoreboard counters and the collision flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      err_waw <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
      err_waw <= waw;
    end
  end

  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      spu_regfile_mp_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
      ) u_rd (
        .clk      (clk),
        .reset    (reset),
        .en       (rd_en[g]),
        .addr     (ra[g]),
        .in_range (in_rng[g]),
        .arr_val  (arr_val[g]),
        .busy     (busy[g]),
        .wr_en    (we),
        .wr_addr  (wa),
        .wr_data  (wd),
        .data     (rq[g]),
        .hazard   (rd_hazard[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_spu_regfile_mp.sv
// Bench for spu_regfile_mp: directed scenarios plus random traffic, checked
// every cycle against an array/counter model of the register file.
module tb_spu_regfile_mp;
  localparam int DATA_W = 128;
  localparam int NREGS  = 128;
  localparam int ADDR_W = 7;
  localparam int NUM_RD = 5;
  localparam int NUM_WR = 2;
  localparam int LAT_W  = 3;

  logic clk = 1'b0;
  logic reset;
  logic [0:NUM_RD-1]        rd_en;
  logic [0:NUM_RD*ADDR_W-1] rd_addr;
  logic [0:NUM_RD*DATA_W-1] rd_data;
  logic [0:NUM_RD-1]        rd_hazard;
  logic [0:NUM_WR-1]        wr_en;
  logic [0:NUM_WR*ADDR_W-1] wr_addr;
  logic [0:NUM_WR*DATA_W-1] wr_data;
  logic [0:NUM_WR-1]        iss_valid;
  logic [0:NUM_WR*ADDR_W-1] iss_addr;
  logic [0:NUM_WR*LAT_W-1]  iss_lat;
  logic                     err_waw;

  spu_regfile_mp #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_hazard(rd_hazard),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_lat(iss_lat),
    .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  // Per-port stimulus, packed onto the DUT vectors below.
  logic              re [NUM_RD];
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic              we [NUM_WR];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic              iv [NUM_WR];
  logic [ADDR_W-1:0] ia [NUM_WR];
  logic [LAT_W-1:0]  il [NUM_WR];

  always_comb begin
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = '0; iss_addr = '0; iss_lat = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_en[i] = re[i];
      rd_addr[i*ADDR_W +: ADDR_W] = ra[i];
    end
    for (int p = 0; p < NUM_WR; p++) begin
      wr_en[p] = we[p];
      wr_addr[p*ADDR_W +: ADDR_W] = wa[p];
      wr_data[p*DATA_W +: DATA_W] = wd[p];
      iss_valid[p] = iv[p];
      iss_addr[p*ADDR_W +: ADDR_W] = ia[p];
      iss_lat[p*LAT_W +: LAT_W] = il[p];
    end
  end

  // Model state: register contents and remaining cycles until each is ready.
  logic [DATA_W-1:0] m_reg [NREGS];
  int                m_cnt [NREGS];
  logic [DATA_W-1:0] e_data [NUM_RD];
  logic              e_haz  [NUM_RD];
  logic              e_err;
  bit                chk_en = 1'b0;
  int                n_cmp = 0;
  int                n_bad = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] port_data(input int i);
    return rd_data[i*DATA_W +: DATA_W];
  endfunction

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NUM_RD; i++) begin
        check($sformatf("rd_data[%0d]", i), port_data(i), e_data[i]);
        check($sformatf("rd_hazard[%0d]", i), DATA_W'(rd_hazard[i]), DATA_W'(e_haz[i]));
      end
      check("err_waw", DATA_W'(err_waw), DATA_W'(e_err));
    end
  end

  task automatic idle();
    reset = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin re[i] = 1'b0; ra[i] = '0; end
    for (int p = 0; p < NUM_WR; p++) begin
      we[p] = 1'b0; wa[p] = '0; wd[p] = '0;
      iv[p] = 1'b0; ia[p] = '0; il[p] = '0;
    end
  endtask

  // Advance one clock: predict outputs from pre-edge state, then update state.
  task automatic step();
    logic [DATA_W-1:0] nd [NUM_RD];
    logic              nh [NUM_RD];
    logic              ne;
    logic              hit;
    ne = 1'b0;
    for (int p = 0; p < NUM_WR; p++)
      for (int q = p + 1; q < NUM_WR; q++)
        if (we[p] && we[q] && wa[p] == wa[q]) ne = 1'b1;
    for (int i = 0; i < NUM_RD; i++) begin
      nd[i] = e_data[i];
      nh[i] = e_haz[i];
      if (re[i]) begin
        hit   = 1'b0;
        nd[i] = m_reg[ra[i]];
        for (int p = 0; p < NUM_WR; p++)
          if (we[p] && wa[p] == ra[i]) begin hit = 1'b1; nd[i] = wd[p]; end
        nh[i] = (m_cnt[ra[i]] != 0) && !hit;
      end
      if (reset) begin nd[i] = '0; nh[i] = 1'b0; end
    end
    if (reset) ne = 1'b0;
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
    end else begin
      for (int r = 0; r < NREGS; r++) if (m_cnt[r] > 0) m_cnt[r]--;
      for (int p = 0; p < NUM_WR; p++)
        if (we[p]) begin m_reg[wa[p]] = wd[p]; m_cnt[wa[p]] = 0; end
      for (int p = 0; p < NUM_WR; p++)
        if (iv[p] && il[p] != '0) m_cnt[ia[p]] = int'(il[p]);
    end
    for (int i = 0; i < NUM_RD; i++) begin e_data[i] = nd[i]; e_haz[i] = nh[i]; end
    e_err = ne;
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [DATA_W-1:0] v6, v12, v20, v31;
  logic [DATA_W-1:0] pat_a5;

  initial begin
    pat_a5 = {16{8'hA5}};
    for (int i = 0; i < NUM_RD; i++) begin e_data[i] = '0; e_haz[i] = 1'b0; end
    e_err = 1'b0;
    idle();
    reset = 1'b1;
    step();
    step();
    chk_en = 1'b1;

    // Reset state: sweep every register on all read ports.
    idle();
    for (int a = 0; a < (NREGS + NUM_RD - 1) / NUM_RD; a++) begin
      for (int i = 0; i < NUM_RD; i++) begin
        re[i] = 1'b1;
        ra[i] = ADDR_W'((a * NUM_RD + i) % NREGS);
      end
      step();
    end
    for (int i = 0; i < NUM_RD; i++) begin re[i] = 1'b1; ra[i] = ADDR_W'(NREGS - 1); end
    step();
    check("reset_r127_data", port_data(4), '0);
    check("reset_r127_haz", DATA_W'(rd_hazard[4]), '0);

    // Bypass on two ports at once, array read on a third.
    idle();
    v6 = rnd128();
    we[1] = 1'b1; wa[1] = 7'd6; wd[1] = v6;
    step();
    idle();
    we[0] = 1'b1; wa[0] = 7'd5; wd[0] = pat_a5;
    re[0] = 1'b1; ra[0] = 7'd5;
    re[3] = 1'b1; ra[3] = 7'd5;
    re[4] = 1'b1; ra[4] = 7'd6;
    step();
    check("bypass_p0", port_data(0), pat_a5);
    check("bypass_p3", port_data(3), pat_a5);
    check("array_p4_r6", port_data(4), v6);
    idle();
    re[1] = 1'b1; ra[1] = 7'd5;
    step();
    check("array_r5", port_data(1), pat_a5);

    // Same-address write on both ports: odd (higher index) wins.
    idle();
    we[0] = 1'b1; wa[0] = 7'd9; wd[0] = DATA_W'(2);
    we[1] = 1'b1; wa[1] = 7'd9; wd[1] = DATA_W'(1);
    step();
    check("waw_pulse", DATA_W'(err_waw), DATA_W'(1));
    idle();
    re[0] = 1'b1; ra[0] = 7'd9;
    step();
    check("waw_winner", port_data(0), DATA_W'(1));
    check("waw_one_cycle", DATA_W'(err_waw), '0);

    // Latency countdown without writeback.
    idle();
    iv[0] = 1'b1; ia[0] = 7'd12; il[0] = 3'd3;
    step();
    idle();
    re[0] = 1'b1; ra[0] = 7'd12;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("lat3_haz_c%0d", k + 1), DATA_W'(rd_hazard[0]), DATA_W'(k < 3));
    end
    // Writeback on the first read cycle clears the hazard and bypasses data.
    idle();
    iv[0] = 1'b1; ia[0] = 7'd12; il[0] = 3'd3;
    step();
    idle();
    v12 = rnd128();
    re[0] = 1'b1; ra[0] = 7'd12;
    we[1] = 1'b1; wa[1] = 7'd12; wd[1] = v12;
    step();
    check("wb_haz_clear", DATA_W'(rd_hazard[0]), '0);
    check("wb_bypass", port_data(0), v12);
    we[1] = 1'b0;
    step();
    check("wb_haz_stays", DATA_W'(rd_hazard[0]), '0);

    // Issue beats writeback on the same register in the same cycle.
    idle();
    v20 = rnd128();
    iv[1] = 1'b1; ia[1] = 7'd20; il[1] = 3'd2;
    we[0] = 1'b1; wa[0] = 7'd20; wd[0] = v20;
    step();
    idle();
    re[2] = 1'b1; ra[2] = 7'd20;
    step();
    check("iss_over_wb_haz", DATA_W'(rd_hazard[2]), DATA_W'(1));
    check("iss_over_wb_data", port_data(2), v20);
    step();
    check("iss_over_wb_haz2", DATA_W'(rd_hazard[2]), DATA_W'(1));
    step();
    check("iss_over_wb_done", DATA_W'(rd_hazard[2]), '0);

    // Reset mid-stream discards the write and pending counters.
    idle();
    iv[0] = 1'b1; ia[0] = 7'd30; il[0] = 3'd7;
    step();
    idle();
    v31 = rnd128();
    reset = 1'b1;
    we[0] = 1'b1; wa[0] = 7'd31; wd[0] = v31;
    we[1] = 1'b1; wa[1] = 7'd31; wd[1] = v31;
    re[0] = 1'b1; ra[0] = 7'd30;
    iv[1] = 1'b1; ia[1] = 7'd31; il[1] = 3'd5;
    step();
    check("rst_data", port_data(0), '0);
    check("rst_err", DATA_W'(err_waw), '0);
    check("rst_haz3", DATA_W'(rd_hazard[3]), '0);
    idle();
    re[0] = 1'b1; ra[0] = 7'd31;
    re[1] = 1'b1; ra[1] = 7'd30;
    step();
    check("rst_no_commit", port_data(0), '0);
    check("rst_cnt_clear", DATA_W'(rd_hazard[1]), '0);

    // Random traffic on a narrow address window to force collisions.
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset = ($urandom_range(0, 255) == 0);
      for (int i = 0; i < NUM_RD; i++) begin
        re[i] = ($urandom_range(0, 3) != 0);
        ra[i] = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      end
      for (int p = 0; p < NUM_WR; p++) begin
        we[p] = ($urandom_range(0, 2) == 0);
        wa[p] = ADDR_W'($urandom_range(0, 15));
        wd[p] = rnd128();
        iv[p] = ($urandom_range(0, 2) == 0);
        ia[p] = ADDR_W'($urandom_range(0, 15));
        il[p] = LAT_W'($urandom);
      end
      step();
    end

    idle();
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spu_regfile_mp.md
Name: spu_regfile_mp

Overview:
Parametrised multi-port register file for the SPU dual-issue pipeline. Any number of read and write ports is supported. Reads are registered, and every read port receives full same-cycle write bypass independently. A per-register pending-write scoreboard reports RAW hazards to issue logic. It replaces the fixed 2-write/5-read register table and is instantiated between decode/issue and the even/odd execution pipes.

Parameters:
DATA_W, 128, register width in bits
NREGS, 128, number of registers
ADDR_W, 7, register address width; NREGS <= 2**ADDR_W
NUM_RD, 5, read ports (default: even ra/rb/rc, odd ra/rb)
NUM_WR, 2, write and issue ports (default: even, odd)
LAT_W, 3, width of the scoreboard latency counter; max latency 2**LAT_W-1

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i in slice i
rd_data  out  NUM_RD*DATA_W  registered read data, port i in slice i
rd_hazard  out  NUM_RD  registered: source register has a write still outstanding
wr_en  in  NUM_WR  writeback enables
wr_addr  in  NUM_WR*ADDR_W  writeback destination addresses
wr_data  in  NUM_WR*DATA_W  writeback values
iss_valid  in  NUM_WR  an instruction issued on this port will write its destination
iss_addr  in  NUM_WR*ADDR_W  destination of the issued instruction
iss_lat  in  NUM_WR*LAT_W  cycles until that destination is written back
err_waw  out  1  registered pulse: two enabled write ports targeted the same address

Slice packing: vectors are big-endian ([0:N*W-1]). Port i occupies bits [i*W : i*W+W-1].

Behaviour:
- Reset (synchronous, takes precedence over all other activity):
  - every register 0, all NREGS including the last;
  - all scoreboard counters 0;
  - rd_data 0, rd_hazard 0, err_waw 0;
  - in-flight reads, writes and issues in the reset cycle are discarded.
- Write:
  - at posedge, each port with wr_en=1 writes reg[wr_addr] <= wr_data.
  - If several enabled ports share an address, the highest-index port wins.
  - err_waw=1 in the following cycle, else 0.
  - Addresses >= NREGS are ignored, with no error.
- Read (1-cycle latency):
  - for each port with rd_en=1, rd_data is loaded at posedge.
  - If any wr_en port in the same cycle matches rd_addr, the data comes from the highest-index matching write port (write-first bypass). Otherwise it comes from the array.
  - Every read port is bypassed independently; a match on one port never suppresses bypass on another.
  - rd_en=0: that port's rd_data and rd_hazard hold their values.
  - Address >= NREGS: rd_data=0.
- Scoreboard: one LAT_W-bit counter per register, next value at each posedge in priority order:
  1. iss_valid with iss_lat != 0 for that address: load iss_lat. Highest-index issue port wins on address collision.
  2. Else a wr_en to that address: clear to 0.
  3. Else if nonzero: decrement.
  - iss_lat=0 is ignored.
- Hazard:
  - rd_hazard[i] is registered with rd_data.
  - It is 1 when rd_en[i]=1, the counter for rd_addr is nonzero, and no wr_en port writes rd_addr in the same cycle.
  - A same-cycle iss_valid to rd_addr does not affect the hazard seen by that read; the new pending state is visible from the next cycle.
- The counter reaching 0 by decrement without a write is legal; the register then reads as ready.
- The block contains no combinational path from inputs to outputs.

Test Plan:
1. Reset then read all 128 regs on 5 ports (rd_en=1) -> every rd_data=0, rd_hazard=0 one cycle later, including reg 127.
2. Write even r5=0xA5..A5 while ports 0 and 3 read r5 and port 4 reads r6 in the same cycle.
   -> Next cycle, ports 0 and 3 = 0xA5..A5 (bypass on both ports) and port 4 = old r6.
   -> A subsequent read of r5 from the array = 0xA5..A5.
3. Even and odd both write r9, odd data=0x1 and even data=0x2.
   -> r9=0x1 and err_waw pulses for exactly one cycle.
4. Issue r12 with lat=3, then read r12 every cycle with no writeback.
   -> rd_hazard=1 for the reads in the 3 cycles after the issue, and 0 from the 4th.
   -> Repeat with a writeback at cycle 1: hazard clears on the read issued that cycle, with bypassed data.
5. In the same cycle, issue r20 with lat=2 on odd and write r20 on even.
   -> Counter=2, and rd_hazard for r20 is 1 in the following cycle.
6. Assert reset mid-stream with counters pending and writes active.
   -> Next cycle all outputs are 0 and all counters clear; the write issued in the reset cycle is not committed.
